// File: rtl/health_isa_pkg.sv
// Shared definitions for the health-calculator custom ISA: opcode, funct3
// codes, field widths, encoder state type and instruction-format helpers.
// The core's instruction decoder imports the same package.
package health_isa_pkg;

    localparam logic [6:0] OPCODE_HEALTH = 7'b0001011;

    localparam int USER_W = 5;
    localparam int VAL_W  = 12;
    localparam int AGE_W  = 6;

    localparam logic [2:0] F3_SET_H = 3'b000;
    localparam logic [2:0] F3_SET_W = 3'b001;
    localparam logic [2:0] F3_BMI   = 3'b010;
    localparam logic [2:0] F3_BMR   = 3'b011;

    // Each non-idle state names the instruction currently presented on the stream.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_H,
        ST_SET_W,
        ST_BMI,
        ST_BMR
    } enc_state_t;

    // I-type: {imm[11:0], rs1=0, funct3, rd, opcode}
    function automatic logic [31:0] enc_itype(input logic [2:0]        f3,
                                              input logic [VAL_W-1:0]  imm,
                                              input logic [USER_W-1:0] rd);
        return {imm, 5'd0, f3, rd, OPCODE_HEALTH};
    endfunction

    // R-type: {funct7, rs2=0, rs1=0, funct3, rd, opcode}
    function automatic logic [31:0] enc_rtype(input logic [2:0]        f3,
                                              input logic [6:0]        f7,
                                              input logic [USER_W-1:0] rd);
        return {f7, 5'd0, 5'd0, f3, rd, OPCODE_HEALTH};
    endfunction

endpackage

// File: rtl/health_instr_encoder_if.sv
// Request channel (host -> encoder) and instruction stream (encoder -> core)
// bundled together. The encoder uses the slave modport; the host/core side
// uses the master modport.
interface health_instr_encoder_if;
    import health_isa_pkg::*;

    // request channel
    logic              req_valid;
    logic              req_ready;
    logic [USER_W-1:0] req_user;
    logic [VAL_W-1:0]  req_height;
    logic [VAL_W-1:0]  req_weight;
    logic              req_gender;
    logic [AGE_W-1:0]  req_age;
    logic [1:0]        req_mode;

    // instruction stream
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic              instr_last;

    // rejection pulse
    logic              err_range;

    modport master (
        output req_valid, req_user, req_height, req_weight, req_gender, req_age, req_mode,
        input  req_ready,
        input  instr_valid, instr, instr_last,
        output instr_ready,
        input  err_range
    );

    modport slave (
        input  req_valid, req_user, req_height, req_weight, req_gender, req_age, req_mode,
        output req_ready,
        output instr_valid, instr, instr_last,
        input  instr_ready,
        output err_range
    );

endinterface

// File: rtl/health_instr_encoder.sv
// Health-calculator instruction issuer: accepts one request and emits
// SET_HEIGHT, SET_WEIGHT and optionally CALC_BMI / CALC_BMR over a
// valid/ready stream. All outputs come straight from registers.
module health_instr_encoder
    import health_isa_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,   // asynchronous, active low
    health_instr_encoder_if.slave  bus
);

    enc_state_t        r_state;
    logic              r_req_ready;
    logic              r_instr_valid;
    logic [31:0]       r_instr;
    logic              r_instr_last;
    logic              r_err_range;

    // captured request fields (height is only needed on the accept cycle)
    logic [USER_W-1:0] r_user;
    logic [VAL_W-1:0]  r_weight;
    logic              r_gender;
    logic [AGE_W-1:0]  r_age;
    logic [1:0]        r_mode;

    logic              w_accept;
    logic              w_reject;
    logic              w_fire;
    logic [6:0]        w_f7;

    assign w_accept = bus.req_valid && r_req_ready;
    // bit 11 set would be sign-extended negative by the core; BMI needs a nonzero height
    assign w_reject = bus.req_height[VAL_W-1] || bus.req_weight[VAL_W-1] ||
                      ((bus.req_height == '0) && bus.req_mode[0]);
    assign w_fire   = r_instr_valid && bus.instr_ready;
    assign w_f7     = {r_gender, r_age};

    // Sequencer: steps through the instruction list, holding each output until consumed.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_last  <= 1'b0;
            r_err_range   <= 1'b0;
            r_user        <= '0;
            r_weight      <= '0;
            r_gender      <= 1'b0;
            r_age         <= '0;
            r_mode        <= '0;
        end else begin
            r_err_range <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_reject) begin
                            r_err_range <= 1'b1;
                        end else begin
                            r_user        <= bus.req_user;
                            r_weight      <= bus.req_weight;
                            r_gender      <= bus.req_gender;
                            r_age         <= bus.req_age;
                            r_mode        <= bus.req_mode;
                            r_state       <= ST_SET_H;
                            r_req_ready   <= 1'b0;
                            r_instr_valid <= 1'b1;
                            r_instr       <= enc_itype(F3_SET_H, bus.req_height, bus.req_user);
                            r_instr_last  <= 1'b0;
                        end
                    end
                end
                ST_SET_H: begin
                    if (w_fire) begin
                        r_state      <= ST_SET_W;
                        r_instr      <= enc_itype(F3_SET_W, r_weight, r_user);
                        r_instr_last <= (r_mode == 2'b00);
                    end
                end
                ST_SET_W: begin
                    if (w_fire) begin
                        if (r_mode[0]) begin
                            r_state      <= ST_BMI;
                            r_instr      <= enc_rtype(F3_BMI, w_f7, r_user);
                            r_instr_last <= !r_mode[1];
                        end else if (r_mode[1]) begin
                            r_state      <= ST_BMR;
                            r_instr      <= enc_rtype(F3_BMR, w_f7, r_user);
                            r_instr_last <= 1'b1;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_req_ready   <= 1'b1;
                            r_instr_valid <= 1'b0;
                            r_instr       <= '0;
                            r_instr_last  <= 1'b0;
                        end
                    end
                end
                ST_BMI: begin
                    if (w_fire) begin
                        if (r_mode[1]) begin
                            r_state      <= ST_BMR;
                            r_instr      <= enc_rtype(F3_BMR, w_f7, r_user);
                            r_instr_last <= 1'b1;
                        end else begin
                            r_state       <= ST_IDLE;
                            r_req_ready   <= 1'b1;
                            r_instr_valid <= 1'b0;
                            r_instr       <= '0;
                            r_instr_last  <= 1'b0;
                        end
                    end
                end
                ST_BMR: begin
                    if (w_fire) begin
                        r_state       <= ST_IDLE;
                        r_req_ready   <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_instr       <= '0;
                        r_instr_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_req_ready   <= 1'b1;
                    r_instr_valid <= 1'b0;
                    r_instr       <= '0;
                    r_instr_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_last  = r_instr_last;
    assign bus.err_range   = r_err_range;

endmodule
